spike_pattern_player: RTL and testbench

- Parametrised multi-channel spike-train source for the spiking-network datapath.
- Stores one LEN-bit spike pattern per input channel and replays all channels in lockstep, MSB first, one bit per step.
- Step rate is programmable; playback is one-shot or looping, with start/stop control.
- Replaces hard-coded per-neuron shift sequences feeding the network's input neurons.

---
 rtl/spike_pattern_player_if.sv | 35 +++
 rtl/spike_pattern_player.sv | 170 +++++++++++++++++
 tb/tb_spike_pattern_player.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spike_pattern_player_if.sv
// Control/status bundle for the spike pattern player.
// master = controller side (loads patterns, starts/stops playback),
// slave  = player side.
interface spike_pattern_player_if #(
  parameter int N_CH  = 3,
  parameter int LEN   = 40,
  parameter int DIV_W = 8
);
  localparam int CNT_W = $clog2(LEN);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             load_en;
  logic [CH_W-1:0]  load_ch;
  logic [LEN-1:0]   load_data;
  logic             load_err;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [DIV_W-1:0] div;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  spikes;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_idx;

  modport master (
    output load_en, load_ch, load_data, start, stop, loop_en, div, ch_en,
    input  load_err, spikes, busy, done, step_idx
  );

  modport slave (
    input  load_en, load_ch, load_data, start, stop, loop_en, div, ch_en,
    output load_err, spikes, busy, done, step_idx
  );
endinterface

// File: rtl/spike_pattern_player.sv
// Multi-channel spike-train source: one LEN-bit pattern per channel,
// all channels replayed in lockstep MSB first at a programmable step rate.

// One channel: pattern storage plus its registered spike output.
module spike_pattern_lane #(
  parameter int LEN   = 40,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [LEN-1:0]   i_data,
  input  logic             i_upd,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_col,
  input  logic             i_en,
  output logic             o_spike
);
  logic [LEN-1:0] r_pat;
  logic           r_spike;

  // Pattern write and spike column select; clear wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= '0;
      r_spike <= 1'b0;
    end else begin
      if (i_wr) r_pat <= i_data;
      if (i_clr)      r_spike <= 1'b0;
      else if (i_upd) r_spike <= r_pat[i_col] & i_en;
    end
  end

  assign o_spike = r_spike;
endmodule

module spike_pattern_player #(
  parameter int N_CH  = 3,
  parameter int LEN   = 40,
  parameter int DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_pattern_player_if.slave bus
);
  localparam int CNT_W = $clog2(LEN);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  // One extra bit so N_CH itself is representable for the range check.
  localparam logic [CH_W:0]    NCH  = (CH_W + 1)'(N_CH);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [DIV_W-1:0] r_tick;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_ch_ok;
  logic             w_adv;
  logic             w_start;
  logic             w_wr;
  logic             w_upd;
  logic             w_clr;
  logic [CNT_W-1:0] w_col;
  logic [N_CH-1:0]  w_spk;

  assign w_ch_ok = ({1'b0, bus.load_ch} < NCH);
  // >= so that lowering div below the running tick ends the step at once.
  assign w_adv   = (r_tick >= bus.div);
  // A load in the same cycle takes precedence; start must be re-asserted.
  assign w_start = bus.start & ~bus.load_en;

  // Lane controls: which column to present next, or blank the outputs.
  always_comb begin
    w_wr  = 1'b0;
    w_upd = 1'b0;
    w_clr = 1'b0;
    w_col = LAST;
    case (r_state)
      S_IDLE: begin
        w_wr = bus.load_en & w_ch_ok;
        if (w_start) w_upd = 1'b1;
      end
      S_PLAY: begin
        if (bus.stop) begin
          w_clr = 1'b1;
        end else if (w_adv) begin
          if (r_idx != '0) begin
            w_upd = 1'b1;
            w_col = r_idx - 1'b1;
          end else if (bus.loop_en) begin
            w_upd = 1'b1;
          end else begin
            w_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Playback FSM: step divider, step index and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= LAST;
      r_tick  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= bus.load_en & ((r_state == S_PLAY) | ~w_ch_ok);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_PLAY;
            r_busy  <= 1'b1;
            r_idx   <= LAST;
            r_tick  <= '0;
          end
        end
        S_PLAY: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_adv) begin
            r_tick <= r_tick + 1'b1;
          end else begin
            r_tick <= '0;
            if (r_idx != '0) begin
              r_idx <= r_idx - 1'b1;
            end else if (bus.loop_en) begin
              r_idx <= LAST;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_idx   <= LAST;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    spike_pattern_lane #(.LEN(LEN), .CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_wr && (bus.load_ch == CH_W'(c))),
      .i_data  (bus.load_data),
      .i_upd   (w_upd),
      .i_clr   (w_clr),
      .i_col   (w_col),
      .i_en    (bus.ch_en[c]),
      .o_spike (w_spk[c])
    );
  end

  assign bus.spikes   = w_spk;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.load_err = r_err;
  assign bus.step_idx = r_idx;
endmodule

// File: tb/tb_spike_pattern_player.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs,
// a negedge monitor pops and compares.
module tb_spike_pattern_player;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_pattern_player_if #(.N_CH(3), .LEN(40), .DIV_W(8)) bus();

  spike_pattern_player #(.N_CH(3), .LEN(40), .DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0] sp;
    logic       bz;
    logic       dn;
    logic       le;
    logic [5:0] ix;
    bit         cix;
    string      nm;
  } rec_t;

  rec_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [39:0] tp [3];

  function automatic rec_t mk(logic [2:0] sp, logic bz, logic dn, logic le,
                              logic [5:0] ix, bit cix, string nm);
    rec_t r;
    r.sp = sp; r.bz = bz; r.dn = dn; r.le = le; r.ix = ix; r.cix = cix; r.nm = nm;
    return r;
  endfunction

  function automatic logic [2:0] col(int b, logic [2:0] en);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = tp[c][b] & en[c];
    return r;
  endfunction

  // Expectation for the outputs right after the next rising edge.
  task automatic tick_exp(input rec_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  // Expectation for the outputs as they stand now (no edge in between).
  task automatic now_exp(input rec_t e);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      rec_t e;
      e = q.pop_front();
      n_vec++;
      if (bus.spikes !== e.sp || bus.busy !== e.bz || bus.done !== e.dn ||
          bus.load_err !== e.le || (e.cix && bus.step_idx !== e.ix)) begin
        n_bad++;
        $display("FAIL %s @%0t: got sp=%b busy=%b done=%b err=%b idx=%0d, want sp=%b busy=%b done=%b err=%b idx=%0d",
                 e.nm, $time, bus.spikes, bus.busy, bus.done, bus.load_err, bus.step_idx,
                 e.sp, e.bz, e.dn, e.le, e.ix);
      end
    end
  end

  task automatic load(input logic [1:0] ch, input logic [39:0] d, input logic err, input string nm);
    bus.load_en = 1'b1; bus.load_ch = ch; bus.load_data = d;
    tick_exp(mk(3'b000, 1'b0, 1'b0, err, 6'd39, 1'b1, nm));
    bus.load_en = 1'b0;
    if (ch < 2'd3) tp[ch] = d;
  endtask

  // One-shot run; optionally attempts an illegal load during step 5.
  task automatic run(input logic [2:0] en, input int d, input bit inj, input string nm);
    logic eflag;
    eflag = 1'b0;
    bus.ch_en = en; bus.div = 8'(d); bus.loop_en = 1'b0; bus.start = 1'b1;
    for (int s = 0; s < 40; s++) begin
      for (int h = 0; h <= d; h++) begin
        tick_exp(mk(col(39 - s, en), 1'b1, 1'b0, eflag, 6'(39 - s), 1'b1, nm));
        bus.start = 1'b0;
        eflag = 1'b0;
        if (inj && s == 5 && h == 0) begin
          bus.load_en = 1'b1; bus.load_ch = 2'd1; bus.load_data = '0; eflag = 1'b1;
        end else begin
          bus.load_en = 1'b0;
        end
      end
    end
    tick_exp(mk(3'b000, 1'b0, 1'b1, 1'b0, 6'd39, 1'b1, {nm, "_done"}));
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, {nm, "_idle"}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < 3; c++) tp[c] = '0;
    bus.load_en = 1'b0; bus.load_ch = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    bus.div = '0; bus.ch_en = 3'b111;
    #1;
    now_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, "reset"));
    @(posedge clk); #1;
    rst_n = 1'b1;

    load(2'd0, 40'hAAAAAAAAAA, 1'b0, "load0");
    load(2'd1, 40'h5555555555, 1'b0, "load1");
    load(2'd2, 40'h060C183060, 1'b0, "load2");
    load(2'd3, 40'hFFFFFFFFFF, 1'b1, "load_bad_ch");

    run(3'b111, 0, 1'b0, "oneshot_d0");
    run(3'b111, 2, 1'b0, "oneshot_d2");

    // Looping playback then stop.
    bus.loop_en = 1'b1; bus.div = '0; bus.ch_en = 3'b111; bus.start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick_exp(mk(col(39 - (k % 40), 3'b111), 1'b1, 1'b0, 1'b0, 6'(39 - (k % 40)), 1'b1, "loop"));
      bus.start = 1'b0;
    end
    bus.stop = 1'b1;
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "stop"));
    bus.stop = 1'b0; bus.loop_en = 1'b0;
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "stop_idle"));

    run(3'b111, 0, 1'b1, "ld_in_play");
    run(3'b111, 0, 1'b0, "replay");
    run(3'b110, 0, 1'b0, "mask");

    // Async reset mid-playback.
    bus.ch_en = 3'b111; bus.div = '0; bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick_exp(mk(col(39 - k, 3'b111), 1'b1, 1'b0, 1'b0, 6'(39 - k), 1'b1, "pre_rst"));
      bus.start = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    now_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, "async_rst"));
    for (int c = 0; c < 3; c++) tp[c] = '0;
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, "rst_hold"));
    rst_n = 1'b1;
    run(3'b111, 0, 1'b0, "after_rst");

    // Load and start together: load wins, start ignored.
    bus.load_en = 1'b1; bus.load_ch = 2'd0; bus.load_data = 40'hF0F0F0F0F0; bus.start = 1'b1;
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, "load_start"));
    bus.load_en = 1'b0; bus.start = 1'b0;
    tp[0] = 40'hF0F0F0F0F0;
    tick_exp(mk(3'b000, 1'b0, 1'b0, 1'b0, 6'd39, 1'b1, "load_start_idle"));
    run(3'b111, 0, 1'b0, "new_pat");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
